// File: rtl/jtag_dr_scan_master_if.sv
// Command handshake and scan-pin bundle between a host and jtag_dr_scan_master.
// The master modport is the scan initiator's side; slave is the host/chain side.
interface jtag_dr_scan_master_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic             tap_reset;
  logic [WIDTH-1:0] shift_data_in;
  logic [WIDTH-1:0] shift_data_out;
  logic             busy;
  logic             done;
  logic             tck;
  logic             tms;
  logic             tdi;
  logic             tdo;

  modport master (
    input  start, tap_reset, shift_data_in, tdo,
    output shift_data_out, busy, done, tck, tms, tdi
  );

  modport slave (
    output start, tap_reset, shift_data_in, tdo,
    input  shift_data_out, busy, done, tck, tms, tdi
  );
endinterface

// File: rtl/jtag_dr_scan_master.sv
// JTAG initiator: walks the TAP from Run-Test/Idle through one DR scan (or a
// TAP reset sequence) and back, shifting a WIDTH-bit word LSB first.
module jtag_dr_scan_master #(
  parameter int WIDTH   = 5,
  parameter int TCK_DIV = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  jtag_dr_scan_master_if.master bus
);
  localparam int BCW = $clog2(WIDTH + 1);
  localparam int DCW = (TCK_DIV < 2) ? 1 : $clog2(TCK_DIV);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(TCK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    TLR         = 4'd1,
    TLR_RTI     = 4'd2,
    SEL_DR      = 4'd3,
    CAP_DR      = 4'd4,
    ENTER_SHIFT = 4'd5,
    SHIFT       = 4'd6,
    EXIT1       = 4'd7,
    UPDATE      = 4'd8
  } state_t;

  state_t           state_r, state_s;
  logic [DCW-1:0]   div_r, div_s;
  logic [BCW-1:0]   bit_r, bit_s;
  logic [2:0]       tlr_r, tlr_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic [WIDTH-1:0] cap_r, cap_s;
  logic [WIDTH-1:0] sdo_r, sdo_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             tck_r, tck_s;
  logic             tms_r, tms_s;
  logic             tdi_r, tdi_s;
  logic             bit_end_s;
  logic             finish_s;

  // TMS value the target must see on the TCK bit issued in a given state.
  function automatic logic bit_tms(input state_t st, input logic last_bit);
    logic tms_v;
    case (st)
      TLR, SEL_DR, EXIT1:                   tms_v = 1'b1;
      TLR_RTI, CAP_DR, ENTER_SHIFT, UPDATE: tms_v = 1'b0;
      SHIFT:                                tms_v = last_bit;
      default:                              tms_v = 1'b1;
    endcase
    return tms_v;
  endfunction

  // State and output registers; rst_n abandons any scan in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      div_r   <= {DCW{1'b0}};
      bit_r   <= {BCW{1'b0}};
      tlr_r   <= 3'd0;
      data_r  <= {WIDTH{1'b0}};
      cap_r   <= {WIDTH{1'b0}};
      sdo_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      tck_r   <= 1'b0;
      tms_r   <= 1'b1;
      tdi_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      bit_r   <= bit_s;
      tlr_r   <= tlr_s;
      data_r  <= data_s;
      cap_r   <= cap_s;
      sdo_r   <= sdo_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      tck_r   <= tck_s;
      tms_r   <= tms_s;
      tdi_r   <= tdi_s;
    end
  end

  // Command accept, TCK phase timing and per-bit state advance.
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    bit_s     = bit_r;
    tlr_s     = tlr_r;
    data_s    = data_r;
    cap_s     = cap_r;
    sdo_s     = sdo_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    tck_s     = tck_r;
    tms_s     = tms_r;
    tdi_s     = tdi_r;
    bit_end_s = 1'b0;
    finish_s  = 1'b0;

    if (state_r == IDLE) begin
      tck_s = 1'b0;
      div_s = {DCW{1'b0}};
      // The done cycle itself is not an accept slot.
      if (!done_r && bus.tap_reset) begin
        state_s = TLR;
        tlr_s   = 3'd0;
        busy_s  = 1'b1;
        tms_s   = 1'b1;
        tdi_s   = 1'b0;
      end else if (!done_r && bus.start) begin
        state_s = SEL_DR;
        data_s  = bus.shift_data_in;
        busy_s  = 1'b1;
        tms_s   = 1'b1;
        tdi_s   = 1'b0;
      end else begin
        state_s = IDLE;
      end
    end else if (div_r != DIV_LAST) begin
      div_s = div_r + DCW'(1);
    end else begin
      div_s     = {DCW{1'b0}};
      tck_s     = ~tck_r;
      bit_end_s = tck_r;
    end

    // A bit ends on the edge that drops TCK: sample tdo, then set up the next bit.
    if (bit_end_s) begin
      case (state_r)
        TLR: begin
          if (tlr_r == 3'd4) begin
            state_s = TLR_RTI;
          end else begin
            tlr_s = tlr_r + 3'd1;
          end
        end
        SEL_DR:      state_s = CAP_DR;
        CAP_DR:      state_s = ENTER_SHIFT;
        ENTER_SHIFT: begin
          state_s = SHIFT;
          bit_s   = {BCW{1'b0}};
        end
        SHIFT: begin
          data_s         = data_r >> 1'b1;
          cap_s          = cap_r >> 1'b1;
          cap_s[WIDTH-1] = bus.tdo;
          if (bit_r == LAST_BIT) begin
            state_s = EXIT1;
          end else begin
            bit_s = bit_r + BCW'(1);
          end
        end
        EXIT1:       state_s = UPDATE;
        UPDATE: begin
          finish_s = 1'b1;
          sdo_s    = cap_r;
        end
        TLR_RTI:     finish_s = 1'b1;
        default:     finish_s = 1'b1;
      endcase
      if (finish_s) begin
        state_s = IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b1;
      end else begin
        tms_s = bit_tms(state_s, bit_s == LAST_BIT);
        tdi_s = (state_s == SHIFT) ? data_s[0] : 1'b0;
      end
    end else begin
      finish_s = 1'b0;
    end
  end

  assign bus.shift_data_out = sdo_r;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.tck            = tck_r;
  assign bus.tms            = tms_r;
  assign bus.tdi            = tdi_r;
endmodule

// File: doc/jtag_dr_scan_master.md
# jtag_dr_scan_master

Host-side JTAG initiator that drives TCK/TMS/TDI into a boundary-scan cell chain and collects TDO. It walks the target TAP from Run-Test/Idle through a full DR scan (Select, Capture, Shift, Exit1, Update) and back to Run-Test/Idle. It shifts a WIDTH-bit word in and captures the WIDTH-bit word shifted out. It also issues a TAP reset sequence on request. It sits in the test/bring-up fabric as the master end of the scan interface the BSC chains implement.

## Interface
- WIDTH, 5: scan chain length in bits (≥1).
- TCK_DIV, 2: clk cycles per TCK half-period (≥1).

- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a DR scan; sampled only when busy=0.
- tap_reset  in  1  request the TAP reset sequence; sampled only when busy=0.
- shift_data_in  in  WIDTH  word to shift into the chain; latched on command accept.
- shift_data_out  out  WIDTH  word captured from tdo; valid from done, held until next accepted start.
- busy  out  1  high while a command runs.
- done  out  1  one-cycle pulse at command completion.
- tck  out  1  scan clock, registered.
- tms  out  1  TAP mode select, registered.
- tdi  out  1  scan data to chain, registered.
- tdo  in  1  scan data from chain.

## Operation
- Reset values: tck=0, tms=1, tdi=0, busy=0, done=0, shift_data_out=0. FSM is in IDLE. The target TAP is treated as being in Run-Test/Idle.
- Command accept happens in IDLE only. tap_reset has priority when both are high in the same cycle; the start is dropped. Commands raised while busy=1 are ignored, not queued.
- Each TCK bit consists of a low phase then a high phase, each TCK_DIV clk cycles long.
  - tms/tdi update on the clk edge that begins the low phase (TCK falling edge).
  - tdo is sampled on the clk edge that ends the high phase, just before TCK falls.
- FSM states and the TMS bit issued in each:
  - IDLE: tck held 0; tms/tdi hold their last values.
  - TLR: 5 bits, TMS=1 (counter 0..4).
  - TLR_RTI: 1 bit, TMS=0; the command then ends.
  - SEL_DR: TMS=1.
  - CAP_DR: TMS=0.
  - ENTER_SHIFT: TMS=0.
  - SHIFT: WIDTH bits. TMS=0 on bits 0..WIDTH-2 and TMS=1 on bit WIDTH-1. tdi = shift_data_in[k] on bit k (LSB first). The tdo sample of bit k goes to shift_data_out[k].
  - EXIT1: TMS=1 (moves to Update-DR).
  - UPDATE: TMS=0 (moves to Run-Test/Idle); the command then ends.
- When not in SHIFT, tdi=0.
- WIDTH=1: SHIFT issues a single bit with TMS=1.
- Bit counter width is clog2(WIDTH+1). It resets at SHIFT entry and never wraps past WIDTH-1.
- shift_data_out is written only in the done cycle. A tap_reset command leaves it unchanged.

## Timing
- busy rises the cycle after the accept and falls in the same cycle that done pulses.
- DR scan length: (WIDTH+5) TCK periods = (WIDTH+5)·2·TCK_DIV clk cycles from the first tck low phase to the final falling edge.
- TAP reset length: 6 TCK periods = 12·TCK_DIV clk cycles.
- done pulses on the clk cycle after the final TCK falling edge. tck is 0 at that point.
- A new command is accepted earliest on the cycle after done.
- If rst_n is asserted mid-command, all outputs take their reset values immediately and asynchronously. The partial scan is discarded and shift_data_out is cleared. Software must issue tap_reset before the next start.
- tck is glitch-free: it changes only at half-period boundaries.

## Test plan
- WIDTH=5, TCK_DIV=2, with a TAP + 5-bit chain model preloaded to 5'b01011. Start with shift_data_in=5'b10110.
  - Required: shift_data_out=5'b01011 at done; model register=5'b10110; busy high for exactly 40 clk cycles.
- Same setup, issue a second scan with shift_data_in=5'b00001 → shift_data_out=5'b10110.
- TMS trace for one DR scan, sampled at TCK rising edges → 1,0,0,0,0,0,0,1,1,0. tdi during SHIFT edges equals shift_data_in LSB first.
- tap_reset with start asserted in the same cycle → TMS trace 1,1,1,1,1,0 (6 TCK); no scan occurs; shift_data_out unchanged; one done pulse.
- start pulsed twice while busy → exactly one scan and one done. Then rst_n low during SHIFT bit 2 → tck=0, tms=1, busy=0, shift_data_out=0 immediately.
- WIDTH=1, TCK_DIV=1: scan of 1'b1 against a model holding 1'b0 → shift_data_out=1'b0; completes in 12 clk cycles; TMS trace 1,0,0,1,1,0.
